i3c_target_data_engine: RTL

Target-side (responder) data engine for the I3C private transfer data phase, the counterpart of the controller data handler. For a controller write it deserializes SDA into bytes and checks the T-bit (odd parity). For a controller read it serializes bytes onto SDA and drives the end-of-data T-bit. It sits between the target protocol FSM and the SDA pad, using SCL/SDA already synchronized to clk_i.

---
 rtl/i3c_target_data_engine.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/i3c_target_data_engine.sv
// I3C target-side private-transfer data engine: receives controller writes with
// T-bit parity checking and serializes controller reads with an end-of-data T-bit.
module i3c_target_data_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  xfer_en_i,
  input  logic                  is_read_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_last_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  rx_par_err_o,
  output logic                  tx_underrun_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  byte_cnt_o
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] ALL_BITS = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, RX_BITS, RX_TBIT, TX_LOAD, TX_BITS, TX_TBIT, DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic                    scl_q;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [BW-1:0]           bit_cnt_reg, bit_cnt_next;
  logic                    last_reg, last_next;
  logic                    sda_reg, sda_next;
  logic                    oe_reg, oe_next;
  logic [DATA_WIDTH-1:0]   rx_data_reg, rx_data_next;
  logic                    rx_valid_reg, rx_valid_next;
  logic                    par_err_reg, par_err_next;
  logic                    underrun_reg, underrun_next;
  logic                    done_reg, done_next;
  logic [CNT_WIDTH-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [CNT_WIDTH-1:0]    byte_cnt_inc;
  logic                    rise, fall;

  assign rise = scl_i & ~scl_q;
  assign fall = ~scl_i & scl_q;
  assign byte_cnt_inc = (&byte_cnt_reg) ? byte_cnt_reg : byte_cnt_reg + 1'b1;

  // Gated by xfer_en_i so no handshake is offered in the cycle an abort is seen.
  assign tx_ready_o    = (state_reg == TX_LOAD) && xfer_en_i;
  assign sda_o         = sda_reg;
  assign sda_oe_o      = oe_reg;
  assign rx_data_o     = rx_data_reg;
  assign rx_valid_o    = rx_valid_reg;
  assign rx_par_err_o  = par_err_reg;
  assign tx_underrun_o = underrun_reg;
  assign done_o        = done_reg;
  assign byte_cnt_o    = byte_cnt_reg;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    last_next     = last_reg;
    sda_next      = sda_reg;
    oe_next       = oe_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    par_err_next  = par_err_reg;
    underrun_next = 1'b0;
    done_next     = 1'b0;
    byte_cnt_next = byte_cnt_reg;

    if (state_reg != IDLE && !xfer_en_i) begin
      state_next   = IDLE;
      sda_next     = 1'b1;
      oe_next      = 1'b0;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          sda_next      = 1'b1;
          oe_next       = 1'b0;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          if (xfer_en_i) state_next = is_read_i ? TX_LOAD : RX_BITS;
        end
        RX_BITS: begin
          if (rise) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], sda_i};
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next = '0;
              state_next   = RX_TBIT;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
        RX_TBIT: begin
          if (rise) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            par_err_next  = ~(^{shift_reg, sda_i});
            byte_cnt_next = byte_cnt_inc;
            state_next    = RX_BITS;
          end
        end
        TX_LOAD: begin
          // Handshake takes priority over a coincident falling edge.
          if (tx_valid_i) begin
            shift_next   = tx_data_i;
            last_next    = tx_last_i;
            sda_next     = tx_data_i[DATA_WIDTH-1];
            oe_next      = 1'b1;
            bit_cnt_next = '0;
            state_next   = TX_BITS;
          end else if (fall) begin
            underrun_next = 1'b1;
            sda_next      = 1'b1;
            oe_next       = 1'b0;
            state_next    = DONE;
          end
        end
        TX_BITS: begin
          // A fall before the first counted rise belongs to the previous bit slot.
          if (rise) begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end else if (fall && bit_cnt_reg != '0) begin
            if (bit_cnt_reg == ALL_BITS) begin
              sda_next     = ~last_reg;
              bit_cnt_next = '0;
              state_next   = TX_TBIT;
            end else begin
              shift_next = shift_reg << 1;
              sda_next   = shift_reg[DATA_WIDTH-2];
            end
          end
        end
        TX_TBIT: begin
          if (rise) begin
            byte_cnt_next = byte_cnt_inc;
            if (last_reg) begin
              sda_next   = 1'b1;
              oe_next    = 1'b0;
              done_next  = 1'b1;
              state_next = DONE;
            end else begin
              state_next = TX_LOAD;
            end
          end
        end
        DONE: begin
          sda_next = 1'b1;
          oe_next  = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      scl_q        <= 1'b1;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      last_reg     <= 1'b0;
      sda_reg      <= 1'b1;
      oe_reg       <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      par_err_reg  <= 1'b0;
      underrun_reg <= 1'b0;
      done_reg     <= 1'b0;
      byte_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      scl_q        <= scl_i;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      last_reg     <= last_next;
      sda_reg      <= sda_next;
      oe_reg       <= oe_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      par_err_reg  <= par_err_next;
      underrun_reg <= underrun_next;
      done_reg     <= done_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

endmodule
